// File: rtl/mem_arbiter.sv
// Two-port (core / program loader) arbiter in front of a single-port memory.
// One transaction in flight at a time: IDLE -> ACCESS -> WAIT x MEM_LAT -> RESP.
// Contention is resolved round robin; ldr_lock masks new core grants.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              core_ack,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              core_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // WAIT spans MEM_LAT cycles: load MEM_LAT-1 and leave when the count hits zero.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state;
    logic              pri;       // 0 = core wins a tie, 1 = loader wins a tie
    logic              gnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              core_ack_q;
    logic              ldr_ack_q;
    logic              mem_en_q;
    logic              mem_we_q;

    logic              core_elig;
    logic              ldr_elig;
    logic              pick_ldr;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration: lock only gates the core; a tie goes to the port pri points at.
    assign core_elig = core_req & ~ldr_lock;
    assign ldr_elig  = ldr_req;
    assign pick_ldr  = ldr_elig & (~core_elig | pri);
    assign sel_we    = pick_ldr ? ldr_we    : core_we;
    assign sel_addr  = pick_ldr ? ldr_addr  : core_addr;
    assign sel_wdata = pick_ldr ? ldr_wdata : core_wdata;

    // Transaction FSM; command and ack outputs are registered with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pri        <= 1'b0;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 4'd0;
            rdata_q    <= '0;
            core_ack_q <= 1'b0;
            ldr_ack_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            core_ack_q <= 1'b0;
            ldr_ack_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_elig || ldr_elig) begin
                        gnt       <= pick_ldr;
                        pri       <= ~pick_ldr;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) rdata_q <= mem_rdata;
                        core_ack_q <= ~gnt;
                        ldr_ack_q  <= gnt;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign core_ack   = core_ack_q;
    assign ldr_ack    = ldr_ack_q;
    assign rdata      = rdata_q;
    assign core_stall = core_req & ~core_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign busy       = (state != IDLE);
    assign grant_id   = gnt;
    assign state_out  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus predicts each transaction's
// grant cycle and data from the arbitration rules, a negedge monitor checks
// the DUT cycle by cycle against the oldest expected transaction.
module tb_mem_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ldr_lock;
    logic        core_ack, ldr_ack, core_stall, mem_en, mem_we, busy, grant_id;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state_out;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .core_req(req[0]), .core_we(we[0]), .core_addr(addr[0]), .core_wdata(wdata[0]),
        .ldr_req(req[1]), .ldr_we(we[1]), .ldr_addr(addr[1]), .ldr_wdata(wdata[1]),
        .ldr_lock(ldr_lock), .core_ack(core_ack), .ldr_ack(ldr_ack), .rdata(rdata),
        .core_stall(core_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id),
        .state_out(state_out));

    // ---------------- bookkeeping ----------------
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    int cyc = 0;
    logic rst_q;
    always @(posedge clk) begin
        rst_q <= reset;
        cyc   <= reset ? 0 : cyc + 1;
    end

    // ---------------- memory model (DUT side) ----------------
    // Read data is only correct in the cycle MEM_LAT after mem_en; noise otherwise.
    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A5A_0000 | 32'(i * 257));
    endfunction
    logic [31:0] dmem [32];
    int          rd_cyc;
    logic [4:0]  rd_idx;
    logic [31:0] noise;
    always @(posedge clk) begin
        noise <= $urandom;
        if (reset) begin
            for (int i = 0; i < 32; i++) dmem[i] <= init_word(i);
            rd_cyc <= -1;
        end else if (mem_en) begin
            if (mem_we) dmem[mem_addr[4:0]] <= mem_wdata;
            else begin
                rd_cyc <= cyc + L;
                rd_idx <= mem_addr[4:0];
            end
        end
    end
    assign mem_rdata = (cyc == rd_cyc) ? dmem[rd_idx] : noise;

    // ---------------- reference model ----------------
    typedef struct { int g; bit port; bit we; logic [31:0] addr, wdata, rd; } txn_t;
    typedef struct { int c; bit p; } ack_t;
    txn_t        aq[$];
    ack_t        alog[$];
    logic [31:0] mmem [32];
    bit          pri, last_gid;
    int          free_cyc;
    logic [31:0] last_rd;
    bit          pend [2], granted [2], dropped [2];
    int          ack_at [2];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mmem[i] = init_word(i);
        pri = 0; last_gid = 0; free_cyc = 0; last_rd = 0;
        aq.delete();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; granted[p] = 0; dropped[p] = 0; req[p] = 0;
        end
    endtask

    task automatic issue(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        req[p] = 1; we[p] = w; addr[p] = a; wdata[p] = d;
        pend[p] = 1; granted[p] = 0; dropped[p] = 0;
    endtask

    // One arbitration decision per free IDLE cycle, from the inputs as driven now.
    task automatic arb();
        bit ec, el, w;
        txn_t t;
        if (cyc < free_cyc) return;
        ec = req[0] && !ldr_lock;
        el = req[1];
        if (!(ec || el)) return;
        w = (ec && el) ? pri : el;
        t.g = cyc; t.port = w; t.we = we[w]; t.addr = addr[w]; t.wdata = wdata[w];
        if (we[w]) mmem[addr[w][4:0]] = wdata[w];
        else last_rd = mmem[addr[w][4:0]];
        t.rd = last_rd;
        aq.push_back(t);
        pri = !w;
        granted[w] = 1;
        ack_at[w]  = cyc + L + 2;
        free_cyc   = cyc + L + 3;
    endtask

    task automatic begin_cycle();
        @(negedge clk); #1;
        for (int p = 0; p < 2; p++)
            if (pend[p] && granted[p] && cyc == ack_at[p]) begin
                pend[p] = 0; req[p] = 0;
            end
    endtask

    task automatic end_cycle();
        if (!reset) arb();
    endtask

    task automatic do_reset();
        begin_cycle();
        reset = 1;
        model_reset();
    endtask

    task automatic drain();
        int n = 0;
        ldr_lock = 0;
        while ((pend[0] || pend[1] || aq.size() > 0) && n < 300) begin
            begin_cycle(); end_cycle(); n++;
        end
        chk("drain_bounded", 32'(n < 300), 32'd1);
    endtask

    // ---------------- monitor ----------------
    txn_t     m_t;
    int       m_d;
    bit       m_ec, m_el, m_men, m_busy, m_gid;
    logic [1:0] m_st;
    always @(negedge clk) begin
        if (rst_q === 1'b1) begin
            chk("rst_acks", {30'd0, core_ack, ldr_ack}, 32'd0);
            chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_state", 32'(state_out), 32'd0);
            chk("rst_rdata_gid", {rdata[30:0], grant_id}, {last_rd[30:0], 1'b0});
        end else if (rst_q === 1'b0) begin
            m_ec = 0; m_el = 0; m_men = 0; m_busy = 0; m_st = 0; m_gid = last_gid;
            if (aq.size() > 0) begin
                m_t = aq[0]; m_d = cyc - m_t.g;
                m_busy = 1; m_gid = m_t.port; m_men = (m_d == 1);
                m_st = (m_d == 1) ? 2'd1 : (m_d <= L + 1) ? 2'd2 : 2'd3;
                if (m_d == L + 2) begin m_ec = !m_t.port; m_el = m_t.port; end
            end
            chk("core_ack", 32'(core_ack), 32'(m_ec));
            chk("ldr_ack", 32'(ldr_ack), 32'(m_el));
            chk("mem_en", 32'(mem_en), 32'(m_men));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("state_out", 32'(state_out), 32'(m_st));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("core_stall", 32'(core_stall), 32'(req[0] && !m_ec));
            if (m_men) begin
                chk("mem_we", 32'(mem_we), 32'(m_t.we));
                chk("mem_addr", mem_addr, m_t.addr);
                if (m_t.we) chk("mem_wdata", mem_wdata, m_t.wdata);
            end else chk("mem_we_idle", 32'(mem_we), 32'd0);
            if (core_ack || ldr_ack) alog.push_back('{cyc, ldr_ack});
            if (m_ec || m_el) begin
                chk("rdata", rdata, m_t.rd);
                last_gid = m_t.port;
                void'(aq.pop_front());
            end
        end
    end

    // ---------------- latency corners (MEM_LAT = 1 and 15) ----------------
    logic        lreset, lreq1, lreq15, lat_done;
    logic        a1, s1_ld, s1_st, s1_en, s1_we, s1_b, s1_g;
    logic        a15, s15_ld, s15_st, s15_en, s15_we, s15_b, s15_g;
    logic [31:0] r1, r15, s1_a, s1_d, s15_a, s15_d;
    logic [1:0]  s1_s, s15_s;
    logic [31:0] lmem = 32'hC0DE_0001;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(lreset),
        .core_req(lreq1), .core_we(1'b0), .core_addr(32'h8), .core_wdata(32'h0),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_lock(1'b0), .core_ack(a1), .ldr_ack(s1_ld), .rdata(r1), .core_stall(s1_st),
        .mem_en(s1_en), .mem_we(s1_we), .mem_addr(s1_a), .mem_wdata(s1_d),
        .mem_rdata(lmem), .busy(s1_b), .grant_id(s1_g), .state_out(s1_s));

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(15)) u_lat15 (
        .clk(clk), .reset(lreset),
        .core_req(lreq15), .core_we(1'b0), .core_addr(32'h8), .core_wdata(32'h0),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_lock(1'b0), .core_ack(a15), .ldr_ack(s15_ld), .rdata(r15), .core_stall(s15_st),
        .mem_en(s15_en), .mem_we(s15_we), .mem_addr(s15_a), .mem_wdata(s15_d),
        .mem_rdata(lmem), .busy(s15_b), .grant_id(s15_g), .state_out(s15_s));

    initial begin
        int c1, c15;
        lat_done = 0; lreset = 1; lreq1 = 0; lreq15 = 0; c1 = -1; c15 = -1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        lreset = 0; lreq1 = 1; lreq15 = 1;
        for (int lc = 1; lc <= 40; lc++) begin
            @(negedge clk);
            if (a1) begin
                if (c1 < 0) c1 = lc;
                chk("lat1_rdata", r1, 32'hC0DE_0001);
            end
            if (a15) begin
                if (c15 < 0) c15 = lc;
                chk("lat15_rdata", r15, 32'hC0DE_0001);
            end
            #1;
            if (a1) lreq1 = 0;
            if (a15) lreq15 = 0;
        end
        chk("lat1_ack_cycle", 32'(c1), 32'd3);
        chk("lat15_ack_cycle", 32'(c15), 32'd17);
        lat_done = 1;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, drop, ncore;
        reset = 1; ldr_lock = 0;
        for (int p = 0; p < 2; p++) begin we[p] = 0; addr[p] = 0; wdata[p] = 0; end
        model_reset();
        repeat (3) @(posedge clk);

        // Single core read of 0x10 right out of reset.
        begin_cycle(); reset = 0;
        issue(0, 0, 32'h10, 32'h0); end_cycle();
        drain();
        chk("read_ack_cycle", 32'(alog.size() > 0 ? alog[0].c : -1), 32'd4);
        chk("read_rdata", rdata, 32'hDEADBEEF);

        // Loader write; rdata must keep the earlier read value.
        alog.delete();
        begin_cycle(); t0 = cyc; issue(1, 1, 32'h40, 32'h1234_5678); end_cycle();
        drain();
        chk("write_ack_delta", 32'(alog.size() > 0 ? alog[0].c - t0 : -1), 32'd4);
        chk("write_rdata_held", rdata, 32'hDEADBEEF);

        // Both ports requesting continuously from reset: strict alternation.
        do_reset(); alog.delete();
        begin_cycle(); reset = 0;
        issue(0, 0, 32'h3, 32'h0); issue(1, 1, 32'h7, 32'hA1); end_cycle();
        for (int n = 0; n < 40 && alog.size() < 4; n++) begin
            begin_cycle();
            if (!pend[0]) issue(0, 0, $urandom, 32'h0);
            if (!pend[1]) issue(1, 1, $urandom, $urandom);
            end_cycle();
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("rr_ack_cycle", 32'(alog.size() > i ? alog[i].c : -1), 32'(4 + 5 * i));
            chk("rr_ack_port", 32'(alog.size() > i ? alog[i].p : 1'b0), 32'(i % 2));
        end

        // Lock: only loader writes while high; core granted after it falls.
        alog.delete();
        begin_cycle(); ldr_lock = 1; issue(0, 0, $urandom, 0); end_cycle();
        for (int n = 0; n < 30; n++) begin
            begin_cycle();
            if (!pend[1]) issue(1, 1, $urandom, $urandom);
            end_cycle();
        end
        begin_cycle(); ldr_lock = 0; drop = cyc; end_cycle();
        drain();
        ncore = 0;
        foreach (alog[i]) if (!alog[i].p && alog[i].c <= drop) ncore++;
        chk("lock_no_core_ack", 32'(ncore), 32'd0);
        ncore = 0;
        foreach (alog[i]) if (!alog[i].p) ncore++;
        chk("lock_core_after", 32'(ncore), 32'd1);

        // Reset while a core read sits in WAIT: no ack, pri back to core.
        begin_cycle(); issue(0, 0, 32'h10, 0); end_cycle();
        begin_cycle(); end_cycle();
        do_reset(); alog.delete();
        begin_cycle(); reset = 0;
        chk("post_reset_state", 32'(state_out), 32'd0);
        issue(0, 0, 32'h5, 0); issue(1, 1, 32'h9, 32'h77); end_cycle();
        drain();
        chk("post_reset_first_port", 32'(alog.size() > 0 ? alog[0].p : 1'b1), 32'd0);
        chk("post_reset_first_cycle", 32'(alog.size() > 0 ? alog[0].c : -1), 32'd4);

        // Random traffic: random lock, random early req drop after grant.
        repeat (3000) begin
            begin_cycle();
            if ($urandom % 16 == 0) ldr_lock = ~ldr_lock;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom % 3 == 0) issue(p, 1'($urandom % 2), $urandom, $urandom);
                end else if (granted[p] && !dropped[p] && $urandom % 6 == 0) begin
                    req[p] = 0; dropped[p] = 1;
                end
            end
            end_cycle();
        end
        drain();

        wait (lat_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
